// File: rtl/knn_topk_engine.sv
// Streaming k-nearest-neighbour engine. A squared-distance stage feeds a sorted
// top-K insertion stage, and one data point is accepted per cycle.
module knn_topk_engine #(
    parameter int COORD_W = 16,
    parameter int NDIM    = 2,
    parameter int K       = 4,
    parameter int LABEL_W = 8,
    localparam int DIST_W = 2*COORD_W + $clog2(NDIM) + 1,
    localparam int CNT_W  = $clog2(K+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [NDIM*COORD_W-1:0] test_point,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NDIM*COORD_W-1:0] in_point,
    input  logic [LABEL_W-1:0]      in_label,
    input  logic                    in_last,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        nb_count,
    output logic [K*DIST_W-1:0]     nb_dist,
    output logic [K*LABEL_W-1:0]    nb_label
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
    localparam int PROD_W = 2*COORD_W + 2;

    logic [1:0]              state_q, state_d;
    logic [NDIM*COORD_W-1:0] test_q, test_d;
    logic                    s1_valid_q, s1_valid_d;
    logic [DIST_W-1:0]       s1_dist_q, s1_dist_d;
    logic [LABEL_W-1:0]      s1_label_q, s1_label_d;
    logic [DIST_W-1:0]       dist_q [K];
    logic [DIST_W-1:0]       dist_d [K];
    logic [LABEL_W-1:0]      label_q [K];
    logic [LABEL_W-1:0]      label_d [K];
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    beat_s, clear_s;
    logic signed [PROD_W-1:0] prod_s [NDIM];
    logic [DIST_W-1:0]       dist_s;
    logic [CNT_W-1:0]        pos_s;

    assign in_ready = (state_q == ST_RUN);
    assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign nb_count = count_q;
    assign beat_s   = in_valid & in_ready;

    // The difference needs one extra bit, so its square always fits in PROD_W bits.
    for (genvar i = 0; i < NDIM; i++) begin : g_coord
        logic signed [COORD_W-1:0] pc_s, tc_s;
        logic signed [COORD_W:0]   diff_s;
        assign pc_s      = in_point[i*COORD_W +: COORD_W];
        assign tc_s      = test_q[i*COORD_W +: COORD_W];
        assign diff_s    = (COORD_W+1)'(pc_s) - (COORD_W+1)'(tc_s);
        assign prod_s[i] = PROD_W'(diff_s) * PROD_W'(diff_s);
    end

    for (genvar j = 0; j < K; j++) begin : g_pack
        assign nb_dist[j*DIST_W +: DIST_W]    = dist_q[j];
        assign nb_label[j*LABEL_W +: LABEL_W] = label_q[j];
    end

    // Sum of per-coordinate squares.
    always_comb begin
        dist_s = '0;
        for (int i = 0; i < NDIM; i++) begin
            dist_s = dist_s + DIST_W'($unsigned(prod_s[i]));
        end
    end

    // Query control FSM.
    always_comb begin
        state_d = state_q;
        test_d  = test_q;
        clear_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    test_d  = test_point;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (beat_s && in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (!s1_valid_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Distance stage register inputs.
    always_comb begin
        s1_valid_d = beat_s;
        s1_dist_d  = dist_s;
        s1_label_d = in_label;
    end

    // Insert position: valid entries at or below the new distance, so ties land behind.
    always_comb begin
        pos_s = '0;
        for (int j = 0; j < K; j++) begin
            if ((CNT_W'(j) < count_q) && (dist_q[j] <= s1_dist_q)) begin
                pos_s = pos_s + CNT_W'(1);
            end else begin
                pos_s = pos_s;
            end
        end
    end

    // Sorted-list update: shift the tail down by one and drop the last slot.
    always_comb begin
        count_d = count_q;
        for (int j = 0; j < K; j++) begin
            dist_d[j]  = dist_q[j];
            label_d[j] = label_q[j];
        end
        if (clear_s) begin
            count_d = '0;
            for (int j = 0; j < K; j++) begin
                dist_d[j]  = '1;
                label_d[j] = '0;
            end
        end else if (s1_valid_q) begin
            count_d = (count_q == CNT_W'(K)) ? count_q : count_q + CNT_W'(1);
            for (int j = 0; j < K; j++) begin
                if (CNT_W'(j) == pos_s) begin
                    dist_d[j]  = s1_dist_q;
                    label_d[j] = s1_label_q;
                end else if (CNT_W'(j) > pos_s) begin
                    dist_d[j]  = dist_q[(j > 0) ? j - 1 : 0];
                    label_d[j] = label_q[(j > 0) ? j - 1 : 0];
                end else begin
                    dist_d[j]  = dist_q[j];
                    label_d[j] = label_q[j];
                end
            end
        end else begin
            count_d = count_q;
        end
    end

    // State, pipeline and list registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            test_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_dist_q  <= '0;
            s1_label_q <= '0;
            count_q    <= '0;
            for (int j = 0; j < K; j++) begin
                dist_q[j]  <= '1;
                label_q[j] <= '0;
            end
        end else begin
            state_q    <= state_d;
            test_q     <= test_d;
            s1_valid_q <= s1_valid_d;
            s1_dist_q  <= s1_dist_d;
            s1_label_q <= s1_label_d;
            count_q    <= count_d;
            for (int j = 0; j < K; j++) begin
                dist_q[j]  <= dist_d[j];
                label_q[j] <= label_d[j];
            end
        end
    end
endmodule

// File: tb/tb_knn_topk_engine.sv
// Self-checking bench for knn_topk_engine: vector table, directed corner sequences
// and random queries checked against a sorted-list reference model.
module tb_knn_topk_engine;
    localparam int COORD_W = 16;
    localparam int NDIM    = 2;
    localparam int K       = 4;
    localparam int LABEL_W = 8;
    localparam int DIST_W  = 2*COORD_W + $clog2(NDIM) + 1;
    localparam int CNT_W   = $clog2(K+1);
    localparam logic [63:0] ONES = (64'd1 << DIST_W) - 64'd1;

    logic                    clk = 1'b0;
    logic                    rst, start, in_valid, in_ready, in_last, busy, done;
    logic [NDIM*COORD_W-1:0] test_point, in_point;
    logic [LABEL_W-1:0]      in_label;
    logic [CNT_W-1:0]        nb_count;
    logic [K*DIST_W-1:0]     nb_dist;
    logic [K*LABEL_W-1:0]    nb_label;

    always #5 clk = ~clk;

    knn_topk_engine #(.COORD_W(COORD_W), .NDIM(NDIM), .K(K), .LABEL_W(LABEL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .test_point(test_point),
        .in_valid(in_valid), .in_ready(in_ready), .in_point(in_point),
        .in_label(in_label), .in_last(in_last), .busy(busy), .done(done),
        .nb_count(nb_count), .nb_dist(nb_dist), .nb_label(nb_label)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint md[$];
    int     ml[$];
    int     mcount;
    int     qx[$], qy[$], ql[$];

    typedef struct {
        int     tx, ty, px, py, lab;
        longint exp_d;
    } vec_t;
    vec_t vt[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y);
        logic [31:0] r;
        r = {y[15:0], x[15:0]};
        return r;
    endfunction

    function automatic logic [63:0] slot_d(input int j);
        return 64'(nb_dist[j*DIST_W +: DIST_W]);
    endfunction

    function automatic logic [63:0] slot_l(input int j);
        return 64'(nb_label[j*LABEL_W +: LABEL_W]);
    endfunction

    function automatic int rc(input bit narrow);
        if (narrow) return int'($urandom_range(6, 0)) - 3;
        else return int'($urandom_range(65535, 0)) - 32768;
    endfunction

    task automatic add(input int x, input int y, input int l);
        qx.push_back(x); qy.push_back(y); ql.push_back(l);
    endtask

    // Reference: keep K nearest, stable on ties, using plain integer arithmetic.
    task automatic model_insert(input int px, input int py, input int lab, input int tx, input int ty);
        longint dx, dy, d;
        int pos;
        dx = longint'(px) - longint'(tx);
        dy = longint'(py) - longint'(ty);
        d = dx*dx + dy*dy;
        pos = md.size();
        for (int i = 0; i < md.size(); i++) begin
            if (md[i] > d) begin pos = i; break; end
        end
        if (pos < K) begin
            md.insert(pos, d);
            ml.insert(pos, lab);
            if (md.size() > K) begin
                void'(md.pop_back());
                void'(ml.pop_back());
            end
        end
        if (mcount < K) mcount++;
    endtask

    task automatic check_list(input string name);
        check({name, "_cnt"}, 64'(nb_count), 64'(mcount));
        for (int j = 0; j < K; j++) begin
            if (j < md.size()) begin
                check($sformatf("%s_d%0d", name, j), slot_d(j), 64'(md[j]));
                check($sformatf("%s_l%0d", name, j), slot_l(j), 64'(ml[j]));
            end else begin
                check($sformatf("%s_d%0d", name, j), slot_d(j), ONES);
                check($sformatf("%s_l%0d", name, j), slot_l(j), 64'd0);
            end
        end
    endtask

    // Runs one query from IDLE over qx/qy/ql; starts are pulsed into gaps when asked.
    task automatic run_query(input int tx, input int ty, input int gmin, input int gmax, input bit mid_start);
        int cnt_before, lat, gaps;
        md.delete(); ml.delete(); mcount = 0; cnt_before = 0;
        start = 1'b1; test_point = pack(tx, ty);
        tick();
        start = 1'b0; test_point = pack(tx + 7, ty - 3);
        check("clr_cnt", 64'(nb_count), 64'd0);
        check("clr_d0", slot_d(0), ONES);
        check("run_rdy", 64'(in_ready), 64'd1);
        for (int b = 0; b < qx.size(); b++) begin
            gaps = int'($urandom_range(gmax, gmin));
            for (int g = 0; g < gaps; g++) begin
                in_valid = 1'b0; in_point = 32'($urandom); in_label = 8'($urandom); in_last = 1'($urandom);
                if (mid_start) begin start = 1'b1; test_point = pack(100, -100); end
                tick();
                start = 1'b0;
                check("busy_gap", 64'(busy), 64'd1);
            end
            in_valid = 1'b1; in_point = pack(qx[b], qy[b]); in_label = 8'(ql[b]);
            in_last = (b == qx.size() - 1);
            cnt_before = mcount;
            model_insert(qx[b], qy[b], ql[b], tx, ty);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("lat_t1_cnt", 64'(nb_count), 64'(cnt_before));
        check("busy_drain", 64'(busy), 64'd1);
        lat = 0;
        while (!done && lat < 16) begin
            tick();
            lat++;
            if (lat == 1) check_list("t2");
        end
        check("done_lat", 64'(lat), 64'd2);
        check("busy_done", 64'(busy), 64'd0);
        tick();
        check("done_pulse", 64'(done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check_list("final");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        test_point = '0; in_point = '0; in_label = '0;
        vt[0] = '{0, 0, 3, 4, 7, 64'd25};
        vt[1] = '{-5, 2, 1, -6, 9, 64'd100};
        vt[2] = '{32767, 32767, -32768, -32768, 1, 64'd8589672450};
        vt[3] = '{-32768, -32768, 32767, 32767, 2, 64'd8589672450};
        vt[4] = '{10, 10, 10, 10, 3, 64'd0};
        vt[5] = '{-32768, 0, 32767, 0, 4, 64'd4294836225};
        repeat (3) tick();
        start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rdy", 64'(in_ready), 64'd0);
        md.delete(); ml.delete(); mcount = 0;
        check_list("rst");

        for (int v = 0; v < 6; v++) begin
            qx.delete(); qy.delete(); ql.delete();
            add(vt[v].px, vt[v].py, vt[v].lab);
            run_query(vt[v].tx, vt[v].ty, 0, 0, 1'b0);
            check($sformatf("vec%0d_d", v), slot_d(0), 64'(vt[v].exp_d));
            check($sformatf("vec%0d_l", v), slot_l(0), 64'(vt[v].lab));
            check($sformatf("vec%0d_d1", v), slot_d(1), ONES);
        end

        for (int pass = 0; pass < 2; pass++) begin
            qx.delete(); qy.delete(); ql.delete();
            add(3, 4, 1); add(1, 1, 2); add(-2, 0, 3); add(5, 5, 4); add(0, 1, 5);
            run_query(0, 0, pass, 2*pass, pass == 1);
            check("s1_cnt", 64'(nb_count), 64'd4);
            check("s1_d0", slot_d(0), 64'd1);  check("s1_l0", slot_l(0), 64'd5);
            check("s1_d1", slot_d(1), 64'd2);  check("s1_l1", slot_l(1), 64'd2);
            check("s1_d2", slot_d(2), 64'd4);  check("s1_l2", slot_l(2), 64'd3);
            check("s1_d3", slot_d(3), 64'd25); check("s1_l3", slot_l(3), 64'd1);
        end

        in_valid = 1'b1; in_point = pack(0, 0); in_label = 8'd9; in_last = 1'b1;
        repeat (3) tick();
        check("idle_rdy", 64'(in_ready), 64'd0);
        in_valid = 1'b0; in_last = 1'b0;
        tick();
        check("idle_busy2", 64'(busy), 64'd0);
        check_list("idle_hold");

        start = 1'b1; test_point = pack(0, 0);
        tick();
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_point = pack(b, b); in_label = 8'(b); in_last = (b == 2);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        check("drn_busy", 64'(busy), 64'd1);
        check("drn_rdy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drst_busy", 64'(busy), 64'd0);
        check("drst_done", 64'(done), 64'd0);
        md.delete(); ml.delete(); mcount = 0;
        check_list("drst");
        seen = 0;
        repeat (5) begin
            tick();
            if (done) seen++;
        end
        check("drst_nodone", 64'(seen), 64'd0);

        qx.delete(); qy.delete(); ql.delete();
        add(1, 0, 'hA); add(0, 1, 'hB);
        run_query(0, 0, 0, 0, 1'b0);
        check("tie_cnt", 64'(nb_count), 64'd2);
        check("tie_d0", slot_d(0), 64'd1); check("tie_l0", slot_l(0), 64'hA);
        check("tie_d1", slot_d(1), 64'd1); check("tie_l1", slot_l(1), 64'hB);
        check("tie_d2", slot_d(2), ONES);  check("tie_d3", slot_d(3), ONES);

        for (int q = 0; q < 25; q++) begin
            int n, tx, ty;
            bit narrow;
            narrow = (q % 2 == 0);
            n = int'($urandom_range(10, 1));
            qx.delete(); qy.delete(); ql.delete();
            for (int b = 0; b < n; b++) add(rc(narrow), rc(narrow), int'($urandom_range(255, 0)));
            tx = rc(narrow); ty = rc(narrow);
            run_query(tx, ty, 0, q % 3, q % 4 == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
